// File: rtl/half_sub_pkg.sv
// Shared definitions for the half-subtractor lane bank: counter width default
// and the per-lane truth table, expressed as {bout, d} indexed by (a, b).
package half_sub_pkg;

   localparam int CNT_W_DEF = 16;

   // {bout, d} for each (a, b) input pair
   localparam logic [1:0] HS_TT_00 = 2'b00;
   localparam logic [1:0] HS_TT_01 = 2'b11;
   localparam logic [1:0] HS_TT_10 = 2'b01;
   localparam logic [1:0] HS_TT_11 = 2'b00;

   // Table lookup of one lane result, returned as {bout, d}
   function automatic logic [1:0] hs_ref(input logic a, input logic b);
      logic [1:0] r;
      case ({a, b})
         2'b00:   r = HS_TT_00;
         2'b01:   r = HS_TT_01;
         2'b10:   r = HS_TT_10;
         default: r = HS_TT_11;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/half_sub_cell.sv
// One combinational half-subtractor lane: a - b with no borrow-in.
module half_sub_cell (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   // Difference is the parity of the operands; a borrow is needed only for 0 - 1
   always_comb begin
      d    = a ^ b;
      bout = ~a & b;
   end

endmodule

// File: rtl/half_subtractor.sv
// Registered bank of independent half-subtractor lanes with a valid qualifier,
// a registered any-lane-borrowed flag and a saturating borrow-event counter.
module half_subtractor
   import half_sub_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cnt_clr,
   output logic             out_valid,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] bout,
   output logic             borrow_any,
   output logic [CNT_W-1:0] borrow_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] d_c;
   logic [WIDTH-1:0] bout_c;
   logic             borrow_any_c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_sub_cell u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .d    (d_c[i]),
         .bout (bout_c[i])
      );
   end

   // Any lane borrowing this cycle
   always_comb begin
      borrow_any_c = |bout_c;
   end

   // Result registers load only on a valid cycle, so idle-cycle inputs
   // (including X) never reach the state
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         d          <= '0;
         bout       <= '0;
         borrow_any <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            d          <= d_c;
            bout       <= bout_c;
            borrow_any <= borrow_any_c;
         end
      end
   end

   // Borrow-event counter: clear beats increment, saturates instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         borrow_cnt <= '0;
      end else if (cnt_clr) begin
         borrow_cnt <= '0;
      end else if (in_valid && borrow_any_c && (borrow_cnt != CNT_MAX)) begin
         borrow_cnt <= borrow_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_half_subtractor.sv
// Directed and random checks of the half-subtractor bank at three sizes.
module tb_half_subtractor;
   import half_sub_pkg::*;

   logic clk = 1'b0;
   logic rst;

   // WIDTH=1, CNT_W=2: truth table, hold, saturation, mid-stream reset
   logic v1, a1, b1, c1, ov1, d1o, bo1, ba1;
   logic [1:0] cnt1;
   // WIDTH=4: multi-lane directed vector
   logic v4, c4, ov4, ba4;
   logic [3:0] a4, b4, d4o, bo4;
   logic [15:0] cnt4;
   // WIDTH=8: random against the table scoreboard
   logic v8, c8, ov8, ba8;
   logic [7:0] a8, b8, d8o, bo8;
   logic [15:0] cnt8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   half_subtractor #(.WIDTH(1), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cnt_clr(c1),
      .out_valid(ov1), .d(d1o), .bout(bo1), .borrow_any(ba1), .borrow_cnt(cnt1));

   half_subtractor #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cnt_clr(c4),
      .out_valid(ov4), .d(d4o), .bout(bo4), .borrow_any(ba4), .borrow_cnt(cnt4));

   half_subtractor #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cnt_clr(c8),
      .out_valid(ov8), .d(d8o), .bout(bo8), .borrow_any(ba8), .borrow_cnt(cnt8));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step1(input logic iv, input logic ia, input logic ib, input logic clr);
      v1 = iv; a1 = ia; b1 = ib; c1 = clr;
      tick();
   endtask

   logic [7:0]  e_d, e_bo;
   logic        e_ba, e_ov;
   logic [15:0] e_cnt;
   logic [1:0]  tt;

   initial begin
      rst = 1'b1;
      v1 = 0; a1 = 0; b1 = 0; c1 = 0;
      v4 = 0; a4 = 0; b4 = 0; c4 = 0;
      v8 = 0; a8 = 0; b8 = 0; c8 = 0;
      tick(); tick();
      check("rst_ov1",  32'(ov1),  0);
      check("rst_d1",   32'(d1o),  0);
      check("rst_bo1",  32'(bo1),  0);
      check("rst_ba1",  32'(ba1),  0);
      check("rst_cnt1", 32'(cnt1), 0);
      check("rst_ov4",  32'(ov4),  0);
      check("rst_cnt8", 32'(cnt8), 0);
      rst = 1'b0;

      // Truth table, {bout,d}
      step1(1, 0, 0, 0); check("tt00", 32'({bo1, d1o}), 32'b00); check("tt00_ov", 32'(ov1), 1);
      step1(1, 1, 0, 0); check("tt10", 32'({bo1, d1o}), 32'b01); check("tt10_ba", 32'(ba1), 0);
      step1(1, 0, 1, 0); check("tt01", 32'({bo1, d1o}), 32'b11); check("tt01_ba", 32'(ba1), 1);
      step1(1, 1, 1, 0); check("tt11", 32'({bo1, d1o}), 32'b00); check("tt_cnt", 32'(cnt1), 1);

      // Hold while in_valid is low; new operands must be ignored
      step1(1, 1, 0, 0); check("ld_d", 32'(d1o), 1); check("ld_ov", 32'(ov1), 1);
      step1(0, 0, 1, 0);
      check("hold_ov", 32'(ov1), 0);
      check("hold_d",  32'(d1o), 1);
      check("hold_bo", 32'(bo1), 0);
      check("hold_cnt", 32'(cnt1), 1);

      // Saturation at 3 for a 2-bit counter
      step1(1, 0, 1, 0); check("sat_2", 32'(cnt1), 2);
      step1(1, 0, 1, 0); check("sat_3", 32'(cnt1), 3);
      step1(1, 0, 1, 0); check("sat_hold1", 32'(cnt1), 3);
      step1(1, 0, 1, 0); check("sat_hold2", 32'(cnt1), 3);
      step1(1, 0, 1, 1);
      check("clr_pri", 32'(cnt1), 0);
      check("clr_bo",  32'(bo1),  1);

      // Four-lane vector
      v4 = 1; a4 = 4'b0101; b4 = 4'b0011;
      tick();
      v4 = 0;
      check("w4_d",   32'(d4o),  32'b0110);
      check("w4_bo",  32'(bo4),  32'b0010);
      check("w4_ba",  32'(ba4),  1);
      check("w4_ov",  32'(ov4),  1);
      check("w4_cnt", 32'(cnt4), 1);

      // Reset on a valid borrowing cycle discards that result
      rst = 1'b1;
      step1(1, 0, 1, 0);
      check("mrst_ov",  32'(ov1),  0);
      check("mrst_d",   32'(d1o),  0);
      check("mrst_bo",  32'(bo1),  0);
      check("mrst_ba",  32'(ba1),  0);
      check("mrst_cnt", 32'(cnt1), 0);
      check("mrst_d4",  32'(d4o),  0);
      rst = 1'b0;
      step1(0, 0, 1, 0);
      check("post_ov", 32'(ov1), 0);
      check("post_bo", 32'(bo1), 0);
      check("post_cnt", 32'(cnt1), 0);
      step1(1, 0, 1, 0);
      check("resume_ov",  32'(ov1),  1);
      check("resume_db",  32'({bo1, d1o}), 32'b11);
      check("resume_cnt", 32'(cnt1), 1);
      v1 = 0;

      // Random traffic on the eight-lane instance
      e_d = d8o; e_bo = bo8; e_ba = ba8; e_ov = 0; e_cnt = cnt8;
      check("r_start_cnt", 32'(cnt8), 0);
      for (int n = 0; n < 1000; n++) begin
         v8 = 1'($urandom_range(0, 1));
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         c8 = ($urandom_range(0, 31) == 0);
         e_ov = v8;
         if (v8) begin
            for (int i = 0; i < 8; i++) begin
               tt = hs_ref(a8[i], b8[i]);
               e_bo[i] = tt[1];
               e_d[i]  = tt[0];
            end
            e_ba = (e_bo != 8'h00);
         end
         if (c8)
            e_cnt = 16'd0;
         else if (v8 && e_ba && e_cnt != 16'hFFFF)
            e_cnt = e_cnt + 16'd1;
         tick();
         check("r_ov",  32'(ov8),  32'(e_ov));
         check("r_d",   32'(d8o),  32'(e_d));
         check("r_bo",  32'(bo8),  32'(e_bo));
         check("r_ba",  32'(ba8),  32'(e_ba));
         check("r_cnt", 32'(cnt8), 32'(e_cnt));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
